// File: rtl/bus_pkg.sv
// Shared serial-bus definitions used by the slave port and the arbiter/master side.
package bus_pkg;
  localparam int BUS_ADDR_W = 4;
  localparam int BUS_DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_READ   = 3'd4
  } bus_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/slave_mem.sv
// Local register memory: synchronous write, asynchronous read, contents not reset.
module slave_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Out-of-range addresses fold back into the array.
  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % 32'(DEPTH));
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem_q[wrap(waddr)] <= wdata;
  end

  assign rdata = mem_q[wrap(raddr)];
endmodule

// File: rtl/bus_slave_port.sv
// Serial bus slave endpoint: deserialises command/address/data, commits writes
// to local memory and streams read data back MSB-first.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic s_address,
  input  logic s_data,
  input  logic s_valid,
  output logic s_ready,
  output logic rd_data,
  output logic rd_valid,
  output logic err
);
  localparam int CNT_W   = $clog2(max_int(ADDR_W, DATA_W) + 1);
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  bus_state_e          state_q, state_d;
  logic                rw_q, rw_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_shift_q, rd_shift_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_raddr;
  logic [DATA_W-1:0]   mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rw_q       <= 1'b0;
      bit_cnt_q  <= '0;
      stall_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_shift_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      bit_cnt_q  <= bit_cnt_d;
      stall_q    <= stall_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_shift_q <= rd_shift_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // The read port sees the address including the bit being sampled right now.
  assign mem_raddr = ADDR_W'({addr_q, s_address});

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    bit_cnt_d  = bit_cnt_q;
    stall_d    = stall_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_shift_d = rd_shift_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          rw_d      = s_address;
          bit_cnt_d = '0;
          stall_d   = '0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (s_valid) begin
          stall_d   = '0;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (state_q == ST_ADDR) begin
            addr_d = ADDR_W'({addr_q, s_address});
            if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
              bit_cnt_d = '0;
              if (rw_q == RW_WRITE) begin
                state_d = ST_DATA;
              end else begin
                state_d    = ST_READ;
                rd_shift_d = mem_rdata;
              end
            end
          end else begin
            wdata_d = DATA_W'({wdata_q, s_data});
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              state_d   = ST_COMMIT;
            end
          end
        end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
          stall_d = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_READ: begin
        rd_shift_d = rd_shift_q << 1;
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rd_valid_d = (state_d == ST_READ);
  end

  always_comb begin
    s_ready  = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    mem_we   = (state_q == ST_COMMIT);
    rd_data  = rd_shift_q[DATA_W-1];
    rd_valid = rd_valid_q;
    err      = err_q;
  end

  slave_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_bus_slave_port.sv
// Self-checking bench for bus_slave_port: table of directed transactions,
// hand-written reset/abort sequences and random traffic against a transaction model.
module tb_bus_slave_port;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  logic s_address, s_data, s_valid;
  logic s_ready, rd_data, rd_valid, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [16];
  bit         written [16];

  bus_slave_port #(
    .ADDR_W  (4),
    .DATA_W  (8),
    .DEPTH   (16),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_address (s_address),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [7:0] data;
    int         stall_at;
    int         stall_len;
    bit         exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Present inputs for the current cycle, then move to 1 time unit after the next edge.
  task automatic drive(input logic v, input logic a, input logic d);
    s_valid   = v;
    s_address = a;
    s_data    = d;
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction starting in an IDLE cycle; stall_at = number of bits
  // sampled before s_valid drops for stall_len cycles (-1: no stall).
  task automatic run_txn(input string tag, input bit wr, input logic [3:0] addr,
                         input logic [7:0] data, input int stall_at, input int stall_len,
                         input bit exp_err, input logic [7:0] exp_rd);
    logic sa [13];
    logic sd [13];
    int nbits;
    int nlow;
    nbits = wr ? 13 : 5;
    for (int i = 0; i < 13; i++) begin
      sa[i] = rb();
      sd[i] = rb();
    end
    sa[0] = wr;
    for (int i = 0; i < 4; i++) sa[1+i] = addr[3-i];
    if (wr) for (int i = 0; i < 8; i++) sd[5+i] = data[7-i];
    for (int k = 0; k < nbits; k++) begin
      if (k == stall_at) begin
        nlow = exp_err ? TIMEOUT : stall_len;
        for (int j = 0; j < nlow; j++) begin
          chk({tag, " stall s_ready"}, s_ready, 1'b1);
          chk({tag, " stall err"}, err, 1'b0);
          drive(1'b0, rb(), rb());
        end
        if (exp_err) begin
          chk({tag, " err pulse"}, err, 1'b1);
          chk({tag, " abort s_ready"}, s_ready, 1'b1);
          chk({tag, " abort rd_valid"}, rd_valid, 1'b0);
          drive(1'b0, rb(), rb());
          chk({tag, " err single"}, err, 1'b0);
          return;
        end
      end
      chk({tag, " sample s_ready"}, s_ready, 1'b1);
      chk({tag, " sample err"}, err, 1'b0);
      chk({tag, " sample rd_valid"}, rd_valid, 1'b0);
      drive(1'b1, sa[k], sd[k]);
    end
    if (wr) begin
      chk({tag, " commit s_ready"}, s_ready, 1'b0);
      chk({tag, " commit rd_valid"}, rd_valid, 1'b0);
      drive(rb(), rb(), rb());
      mem_m[addr] = data;
      written[addr] = 1'b1;
    end else begin
      for (int r = 0; r < 8; r++) begin
        chk($sformatf("%s read rd_valid b%0d", tag, r), rd_valid, 1'b1);
        chk($sformatf("%s read rd_data b%0d", tag, r), rd_data, exp_rd[7-r]);
        chk($sformatf("%s read s_ready b%0d", tag, r), s_ready, 1'b0);
        drive(rb(), rb(), rb());
      end
      chk({tag, " post-read rd_valid"}, rd_valid, 1'b0);
      chk({tag, " post-read rd_data"}, rd_data, 1'b0);
      chk({tag, " post-read s_ready"}, s_ready, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    logic [3:0] ra;
    bit wr;
    logic [3:0] addr;
    int nb, sat, slen;

    vecs[0]  = '{1'b1, 4'hA, 8'h5C, -1, 0,  1'b0, 8'h00};
    vecs[1]  = '{1'b0, 4'hA, 8'h00, -1, 0,  1'b0, 8'h5C};
    vecs[2]  = '{1'b1, 4'h3, 8'hA5, 3,  3,  1'b0, 8'h00};
    vecs[3]  = '{1'b0, 4'h3, 8'h00, -1, 0,  1'b0, 8'hA5};
    vecs[4]  = '{1'b1, 4'h3, 8'hFF, 9,  15, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 4'h3, 8'h00, -1, 0,  1'b0, 8'hA5};
    vecs[6]  = '{1'b1, 4'h7, 8'h3C, 7,  14, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 4'h7, 8'h00, 2,  14, 1'b0, 8'h3C};
    vecs[8]  = '{1'b0, 4'h7, 8'h00, 4,  15, 1'b1, 8'h00};
    vecs[9]  = '{1'b1, 4'h0, 8'h81, -1, 0,  1'b0, 8'h00};
    vecs[10] = '{1'b1, 4'hF, 8'h7E, 12, 1,  1'b0, 8'h00};
    vecs[11] = '{1'b0, 4'h0, 8'h00, -1, 0,  1'b0, 8'h81};
    vecs[12] = '{1'b0, 4'hF, 8'h00, 1,  5,  1'b0, 8'h7E};

    reset = 1'b0;
    s_valid = 1'b0;
    s_address = 1'b0;
    s_data = 1'b0;
    #3;
    chk("reset s_ready", s_ready, 1'b1);
    chk("reset rd_valid", rd_valid, 1'b0);
    chk("reset rd_data", rd_data, 1'b0);
    chk("reset err", err, 1'b0);
    #9 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
              vecs[i].stall_at, vecs[i].stall_len, vecs[i].exp_err, vecs[i].exp_rd);

    // Reset during the third READ cycle of a read from 4'hA.
    ra = 4'hA;
    drive(1'b1, 1'b0, rb());
    for (int i = 0; i < 4; i++) drive(1'b1, ra[3-i], rb());
    for (int r = 0; r < 2; r++) begin
      chk("rstrd pre rd_valid", rd_valid, 1'b1);
      drive(rb(), rb(), rb());
    end
    chk("rstrd third rd_valid", rd_valid, 1'b1);
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstrd async rd_valid", rd_valid, 1'b0);
    chk("rstrd async rd_data", rd_data, 1'b0);
    chk("rstrd async err", err, 1'b0);
    chk("rstrd async s_ready", s_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #4 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rstrd release s_ready", s_ready, 1'b1);
    run_txn("rstrd reread", 1'b0, 4'hA, 8'h00, -1, 0, 1'b0, mem_m[4'hA]);

    for (int i = 0; i < 80; i++) begin
      wr = rb();
      addr = 4'($urandom_range(0, 15));
      if (!wr && !written[addr]) wr = 1'b1;
      nb = wr ? 13 : 5;
      sat = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, nb - 1));
      slen = int'($urandom_range(0, 17));
      run_txn($sformatf("rnd%0d", i), wr, addr, 8'($urandom_range(0, 255)), sat, slen,
              (sat >= 0) && (slen >= TIMEOUT), mem_m[addr]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_slave_port.md
# bus_slave_port

- Slave-side endpoint of the serial system bus; sits directly downstream of the bus arbiter on one of its slave channels.
- Deserialises a command bit, a local address and write data from the 1-bit `s_address`/`s_data`/`s_valid` lines.
- Commits writes to a local register memory; streams read data back MSB-first on a dedicated serial output.
- Drives `s_ready` so the arbiter can forward backpressure to the connected master.

## Interface
- `ADDR_W`, 4: local word-address width, in bits.
- `DATA_W`, 8: word width, in bits.
- `DEPTH`, 2**ADDR_W: number of memory words.
- `TIMEOUT`, 15: consecutive `s_valid`-low cycles inside a transaction before it is aborted; must be ≥1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `s_address`  in  1  serial command/address bit from arbiter.
- `s_data`  in  1  serial write-data bit from arbiter.
- `s_valid`  in  1  current serial bit is valid.
- `s_ready`  out  1  slave can accept bits this cycle.
- `rd_data`  out  1  serial read data, MSB first, registered.
- `rd_valid`  out  1  `rd_data` valid, registered.
- `err`  out  1  one-cycle pulse on timeout abort, registered.

## Operation
- FSM states: IDLE, ADDR, DATA, COMMIT, READ.
- **IDLE**
  - `s_ready`=1.
  - On `s_valid`=1: latch `s_address` as rw (1 = write, 0 = read), clear counters, go to ADDR.
- **ADDR**
  - `s_ready`=1.
  - Each cycle with `s_valid`=1: shift `s_address` into the address register, MSB first.
  - After ADDR_W bits: rw=1 goes to DATA; rw=0 goes to READ.
- **DATA**
  - `s_ready`=1.
  - Each cycle with `s_valid`=1: shift `s_data` into the write register, MSB first.
  - After DATA_W bits: go to COMMIT.
- **COMMIT**
  - `s_ready`=0.
  - mem[addr] is written at the closing edge; then go to IDLE.
- **READ**
  - `s_ready`=0, `rd_valid`=1.
  - One bit per cycle for exactly DATA_W cycles, no stalling; then go to IDLE.
- **Stall / abort**
  - In ADDR or DATA, a cycle with `s_valid`=0 samples nothing and increments the stall counter; any `s_valid`=1 cycle clears it.
  - When the counter reaches TIMEOUT: pulse `err` for one cycle, go to IDLE, leave memory unchanged.
- `s_valid`, `s_address` and `s_data` are ignored in COMMIT and READ.
- Address arithmetic:
  - Bit counter width is $clog2(max(ADDR_W, DATA_W)+1).
  - Stall counter width is $clog2(TIMEOUT+1).
  - Addresses ≥ DEPTH wrap modulo DEPTH (a no-op when DEPTH = 2**ADDR_W).

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, so `s_ready`=1.
  - `rd_data`=0, `rd_valid`=0, `err`=0.
  - Counters and shift registers cleared.
  - Memory contents are not reset.
- Write with continuous `s_valid`:
  - Sampling spans 1+ADDR_W+DATA_W cycles, then one COMMIT cycle.
  - `s_ready` is low for exactly one cycle.
  - The new value is readable from the next transaction on.
- Read with continuous `s_valid`:
  - On the edge sampling the last address bit, the output shift register loads mem[{addr_shift, s_address}].
  - On the following cycle `rd_valid`=1 and `rd_data`=bit DATA_W-1.
  - `rd_valid` stays high for DATA_W cycles, then drops to 0 with `rd_data`=0.
- Back-to-back: a new transaction may start in the first IDLE cycle after COMMIT or READ.
- `err` is asserted the cycle after the TIMEOUT-th low `s_valid` cycle.
- Reset asserted mid-transaction:
  - Aborts immediately; `rd_valid` drops asynchronously.
  - No partial write occurs.

## Structure
- Shared package `bus_pkg` holds:
  - the state enum type (3-bit encoding) and rw encoding constants, shared with the arbiter/master side;
  - the default widths `BUS_ADDR_W` and `BUS_DATA_W`.
- Sub-module `slave_mem`:
  - DEPTH×DATA_W register array with synchronous write enable and asynchronous read port.
  - No reset.
- The FSM, counters and shift registers live in `bus_slave_port`.

## Test plan
- **Write then read:** write addr 4'hA data 8'h5C, then read addr 4'hA.
  - Read data appears 1 cycle after the last address bit: `rd_data` = 0,1,0,1,1,1,0,0 with `rd_valid` high for 8 cycles.
  - `s_ready` is low during those 8 cycles and during the single COMMIT cycle.
- **Stall:** write addr 4'h3 data 8'hA5 with `s_valid` dropped for 3 cycles after the 2nd address bit.
  - No `err`; the transaction completes.
  - A subsequent read of 4'h3 returns 8'hA5.
- **Timeout:** write addr 4'h3 data 8'hFF, holding `s_valid`=0 for 15 cycles after 4 data bits.
  - `err` pulses once, on the cycle after the 15th low cycle; state returns to IDLE.
  - A read of 4'h3 still returns 8'hA5.
- **Reset mid-read:** assert `reset`=0 during the 3rd READ cycle.
  - `rd_valid`, `rd_data` and `err` go to 0 at once; `s_ready`=1.
  - After release, a read of 4'hA still returns 8'h5C.
- **Ignored inputs and back-to-back:** toggle `s_valid` and `s_data` during COMMIT and READ.
  - No effect on the transaction in progress.
  - A new write started in the first IDLE cycle is accepted and commits correctly.
